gt_tx_framer: RTL and testbench
===============================

// Module: gt_tx_framer
// PURPOSE
//  Transmit-side framer for the 32-bit/4-ctrl GTX TX user interface (8b/10b, ctrl bit = K-char flag per byte).
//  Wraps payload words from a valid/ready source into SOF/payload/EOF frames and fills all other cycles with
//  comma (K28.5) idle words. Every K-char is placed in byte 0 (ctrl 4'b0001), so the far-end RX word aligner locks on byte 0.
//  Sits between the user data source and gt_tx_data/gt_tx_ctrl of the transceiver wrapper, in the tx_clk domain.
// PARAMETERS
//  IDLE_WORD  32'hC5C5_C5BC  idle word: byte0 = K28.5 (8'hBC), bytes3..1 = D5.6; sent with ctrl 4'b0001
//  K_SOF      8'hFB          start-of-frame K-char (K27.7), byte 0
//  K_EOF      8'hFD          end-of-frame K-char (K29.7), byte 0
//  IDLE_GAP   8              minimum idle words between EOF (or reset) and next SOF; 1..255
//  MAX_WORDS  1024           max payload words per frame; 1..65535
// PORTS
//  tx_clk       in   1   GTX TX user clock; all logic on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  tx_en        in   1   allow new frames to start; sampled only in S_IDLE
//  s_data       in   32  payload word, byte 0 transmitted first
//  s_valid      in   1   s_data valid
//  s_last       in   1   s_data is the last word of the frame
//  s_ready      out  1   framer accepts s_data this cycle
//  gt_tx_data   out  32  to transceiver TXDATA
//  gt_tx_ctrl   out  4   to transceiver TXCHARISK
//  frame_done   out  1   1-cycle pulse, the cycle EOF is registered onto gt_tx_*
//  trunc_err    out  1   1-cycle pulse, frame cut at MAX_WORDS without s_last
// BEHAVIOUR
//  Reset (async, rst_n=0): gt_tx_data=IDLE_WORD, gt_tx_ctrl=4'b0001, s_ready=0, frame_done=0, trunc_err=0,
//   state=S_IDLE, gap_cnt=0, wcnt=0, seq=0. Reset mid-frame drops the frame; no EOF is sent.
//  All gt_tx_* and pulse outputs registered; s_ready = (state==S_DATA), decoded from the state register only.
//  Transfer = s_valid & s_ready. Accepted word appears on gt_tx_data exactly 1 cycle later, ctrl 4'b0000.
//  S_IDLE: if tx_en & s_valid & gap_cnt>=IDLE_GAP: load SOF = {seq[15:0], 8'h00, K_SOF}, ctrl 4'b0001,
//   wcnt<=0, -> S_DATA. Otherwise load IDLE_WORD/4'b0001, gap_cnt saturating increment (stops at IDLE_GAP).
//  S_DATA: on transfer load s_data/4'b0000, wcnt<=wcnt+1; if s_last or wcnt+1==MAX_WORDS -> S_EOF,
//   trunc_err pulses in that same load cycle when MAX_WORDS reached with s_last=0.
//   If s_valid=0 (underrun): load IDLE_WORD/4'b0001 as fill; fill not counted; stay in S_DATA.
//  S_EOF: load EOF = {wcnt[15:0], 8'h00, K_EOF}, ctrl 4'b0001; frame_done=1; seq<=seq+1 (wraps 16'hFFFF->0);
//   gap_cnt<=0; -> S_IDLE. Back-to-back frames therefore separated by exactly IDLE_GAP idle words.
//  tx_en deassert mid-frame: current frame completes normally; no new SOF until tx_en=1.
//  s_last with MAX_WORDS reached same cycle: normal EOF, no trunc_err. Single-word frame (s_last on first word) legal.
//  Payload bytes equal to K-codes are sent as data (ctrl 0); only ctrl bits mark K-chars.
//  Outside S_DATA s_data/s_valid/s_last are ignored; s_valid may be held high while s_ready=0.
// TESTING
//  1 Reset release, s_valid=0: gt_tx_* = C5C5_C5BC/0001 every cycle; s_ready stays 0.
//  2 s_valid=1 from reset, 3 words A0..A2, s_last on A2: 8 idles, SOF 0000_00FB/0001, A0,A1,A2/0000,
//    EOF 0003_00FD/0001 with frame_done=1, then 8 idles, next SOF carries seq 0001.
//  3 Underrun: drop s_valid 2 cycles mid-frame -> 2 idle fill words between payload; EOF count excludes fill.
//  4 MAX_WORDS=4, 6-word source without s_last in first 4: 4 payload, trunc_err with 4th word, EOF 0004_00FD.
//  5 tx_en=0 mid-frame: frame finishes with EOF, then idles only while s_valid=1; tx_en=1 -> SOF next load.
//  6 rst_n low during payload: outputs idle/0001 immediately, s_ready=0; after release seq restarts at 0, 8 idles first.

Source files
------------

// File: rtl/gt_tx_framer_if.sv
// Payload source stream into the GTX TX framer: valid/ready handshake with end-of-frame marker.
interface gt_tx_framer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/gt_tx_framer.sv
// GTX TX framer: wraps source words into SOF/payload/EOF frames, fills every other cycle with
// K28.5 idle words. All K-chars sit in byte 0 so the far-end aligner locks on byte 0.
module gt_tx_framer #(
  parameter logic [31:0] IDLE_WORD = 32'hC5C5_C5BC,
  parameter logic [7:0]  K_SOF     = 8'hFB,
  parameter logic [7:0]  K_EOF     = 8'hFD,
  parameter int unsigned IDLE_GAP  = 8,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              tx_clk,
  input  logic              rst_n,
  input  logic              tx_en,
  gt_tx_framer_if.slave     src,
  output logic [31:0]       gt_tx_data,
  output logic [3:0]        gt_tx_ctrl,
  output logic              frame_done,
  output logic              trunc_err
);
  localparam logic [3:0]  CTRL_K = 4'b0001;
  localparam logic [3:0]  CTRL_D = 4'b0000;
  localparam logic [7:0]  GAP    = 8'(IDLE_GAP);
  localparam logic [16:0] MAXW   = 17'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOF} state_t;

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [15:0] wcnt;
  logic [15:0] seq;
  logic [16:0] wcnt_inc;
  logic        at_max;

  // 17-bit increment so MAX_WORDS=65535 compares without wrap
  assign wcnt_inc    = {1'b0, wcnt} + 17'd1;
  assign at_max      = (wcnt_inc == MAXW);
  assign src.s_ready = (state == S_DATA);

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      wcnt       <= '0;
      seq        <= '0;
      gt_tx_data <= IDLE_WORD;
      gt_tx_ctrl <= CTRL_K;
      frame_done <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      trunc_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en && src.s_valid && gap_cnt >= GAP) begin
            gt_tx_data <= {seq, 8'h00, K_SOF};
            gt_tx_ctrl <= CTRL_K;
            wcnt       <= '0;
            state      <= S_DATA;
          end else begin
            gt_tx_data <= IDLE_WORD;
            gt_tx_ctrl <= CTRL_K;
            if (gap_cnt < GAP) gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (src.s_valid) begin
            gt_tx_data <= src.s_data;
            gt_tx_ctrl <= CTRL_D;
            wcnt       <= wcnt_inc[15:0];
            if (src.s_last || at_max) state <= S_EOF;
            trunc_err  <= at_max && !src.s_last;
          end else begin
            // underrun: idle fill keeps the link aligned, not counted as payload
            gt_tx_data <= IDLE_WORD;
            gt_tx_ctrl <= CTRL_K;
          end
        end
        S_EOF: begin
          gt_tx_data <= {wcnt, 8'h00, K_EOF};
          gt_tx_ctrl <= CTRL_K;
          frame_done <= 1'b1;
          seq        <= seq + 16'd1;
          gap_cnt    <= '0;
          state      <= S_IDLE;
        end
        default: begin
          gt_tx_data <= IDLE_WORD;
          gt_tx_ctrl <= CTRL_K;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gt_tx_framer.sv
// Bench for gt_tx_framer: cycle table for the basic frame sequence, then a queue-based
// frame model checking every output word under directed corners and random stimulus.
module tb_gt_tx_framer;
  localparam int G    = 8;
  localparam int MAXW = 4;
  localparam logic [31:0] IDLE = 32'hC5C5_C5BC;
  localparam logic [3:0]  K = 4'b0001, D = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] gt_data;
  logic [3:0]  gt_ctrl;
  logic        frame_done, trunc_err;

  gt_tx_framer_if sif();
  assign sif.s_data  = s_data;
  assign sif.s_valid = s_valid;
  assign sif.s_last  = s_last;

  gt_tx_framer #(.IDLE_GAP(G), .MAX_WORDS(MAXW)) dut (
    .tx_clk(clk), .rst_n(rst_n), .tx_en(tx_en), .src(sif.slave),
    .gt_tx_data(gt_data), .gt_tx_ctrl(gt_ctrl), .frame_done(frame_done), .trunc_err(trunc_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    bit v; logic [31:0] d; bit l;
    logic [31:0] xd; logic [3:0] xc; bit xr, xdone, xtrunc;
  } vec_t;

  function automatic vec_t mk(bit v, logic [31:0] d, bit l, logic [31:0] xd, logic [3:0] xc,
                              bit xr, bit xdone, bit xtrunc);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.xd = xd; t.xc = xc; t.xr = xr; t.xdone = xdone; t.xtrunc = xtrunc;
    return t;
  endfunction

  // ---------------- frame model ----------------
  typedef struct { logic [31:0] d; bit l; } word_t;
  word_t src_q[$];

  bit          m_in, m_eof, xfer, sv_prev, en_prev, pend_close, pend_trunc;
  int          m_gap, m_fcnt;
  logic [15:0] m_seq;
  logic [31:0] pend_d;
  int          frames = 0, sofs = 0, fills = 0, truncs = 0;
  bit          auto_gen = 0, rand_en = 0, en_req = 1;
  int          prob = 100, drop = 0;

  task automatic model_reset();
    src_q.delete();
    m_in = 0; m_eof = 0; xfer = 0; sv_prev = 0; en_prev = 0;
    m_gap = 0; m_fcnt = 0; m_seq = '0;
  endtask

  task automatic gen_frame();
    int len = $urandom_range(1, 7);
    for (int i = 0; i < len; i++)
      src_q.push_back('{($urandom_range(0, 5) == 0) ? 32'hBCFD_FBBC : $urandom, i == len - 1});
  endtask

  // Predict the word the last edge should have produced, compare, then advance the model.
  task automatic monitor();
    logic [31:0] ed; logic [3:0] ec; bit edone, etrunc;
    int kind; // 0 idle, 1 SOF, 2 payload, 3 fill, 4 EOF
    edone = 0; etrunc = 0;
    if (m_eof)                               begin kind = 4; ed = {m_fcnt[15:0], 8'h00, 8'hFD}; ec = K; edone = 1; end
    else if (m_in && xfer)                   begin kind = 2; ed = pend_d; ec = D; etrunc = pend_trunc; end
    else if (m_in)                           begin kind = 3; ed = IDLE; ec = K; end
    else if (m_gap >= G && en_prev && sv_prev) begin kind = 1; ed = {m_seq, 8'h00, 8'hFB}; ec = K; end
    else                                     begin kind = 0; ed = IDLE; ec = K; end
    chk("data", gt_data, ed);
    chk("ctrl", 32'(gt_ctrl), 32'(ec));
    chk("frame_done", 32'(frame_done), 32'(edone));
    chk("trunc_err", 32'(trunc_err), 32'(etrunc));
    if (trunc_err) truncs++;
    case (kind)
      4: begin m_seq++; m_in = 0; m_eof = 0; m_gap = 0; frames++; end
      1: begin m_in = 1; m_fcnt = 0; sofs++; end
      2: begin m_fcnt++; if (pend_close) m_eof = 1; end
      3: fills++;
      default: if (m_gap < G) m_gap++;
    endcase
    chk("s_ready", 32'(sif.s_ready), 32'(m_in && !m_eof));
  endtask

  // Record what the coming edge will see; acceptance follows the model's own ready.
  task automatic decide();
    sv_prev = s_valid; en_prev = tx_en;
    xfer = s_valid && m_in && !m_eof;
    if (xfer) begin
      pend_d     = s_data;
      pend_close = s_last || (m_fcnt + 1 == MAXW);
      pend_trunc = !s_last && (m_fcnt + 1 == MAXW);
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    if (xfer) void'(src_q.pop_front());
    if (src_q.size() == 0 && auto_gen) gen_frame();
    if (rand_en && $urandom_range(0, 49) == 0) en_req = ~en_req;
    tx_en = en_req;
    if (src_q.size() == 0 || drop > 0) begin
      s_valid = 0;
      if (drop > 0) drop--;
    end else s_valid = ($urandom_range(1, 100) <= prob);
    s_data = (src_q.size() != 0) ? src_q[0].d : $urandom;
    s_last = (src_q.size() != 0) ? src_q[0].l : 1'($urandom);
    @(negedge clk);
    monitor();
    decide();
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0; xfer = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    tx_en = en_req;
    @(negedge clk);
    chk("rst_data", gt_data, IDLE);
    chk("rst_ctrl", 32'(gt_ctrl), 32'(K));
    chk("rst_ready", 32'(sif.s_ready), 0);
    decide();
  endtask

  task automatic run_until_frame(input int minf, input int budget, input string name);
    int n = 0;
    while (!(m_in && !m_eof && m_fcnt >= minf) && n < budget) begin cycle(); n++; end
    chk(name, 32'(m_in && !m_eof && m_fcnt >= minf), 1);
  endtask

  initial begin
    vec_t tbl[26];
    int f0, fl0, t0;
    for (int r = 0; r <= 8; r++) tbl[r] = mk(1, 32'hA000_0000, 0, IDLE, K, 0, 0, 0);
    tbl[9]  = mk(1, 32'hA000_0000, 0, 32'h0000_00FB, K, 1, 0, 0);
    tbl[10] = mk(1, 32'hA111_1111, 0, 32'hA000_0000, D, 1, 0, 0);
    tbl[11] = mk(1, 32'hA222_2222, 1, 32'hA111_1111, D, 1, 0, 0);
    tbl[12] = mk(1, 32'hBCFB_FDBC, 1, 32'hA222_2222, D, 0, 0, 0);
    tbl[13] = mk(1, 32'hBCFB_FDBC, 1, 32'h0003_00FD, K, 0, 1, 0);
    for (int r = 14; r <= 21; r++) tbl[r] = mk(1, 32'hBCFB_FDBC, 1, IDLE, K, 0, 0, 0);
    tbl[22] = mk(1, 32'hBCFB_FDBC, 1, 32'h0001_00FB, K, 1, 0, 0);
    tbl[23] = mk(0, 32'h0, 0, 32'hBCFB_FDBC, D, 0, 0, 0);
    tbl[24] = mk(0, 32'h0, 0, 32'h0001_00FD, K, 0, 1, 0);
    tbl[25] = mk(0, 32'h0, 0, IDLE, K, 0, 0, 0);

    // basic frame pair straight out of reset, source valid throughout
    repeat (3) @(posedge clk);
    for (int r = 0; r < 26; r++) begin
      @(posedge clk); #1;
      if (r == 0) rst_n = 1;
      s_valid = tbl[r].v; s_data = tbl[r].d; s_last = tbl[r].l;
      @(negedge clk);
      chk($sformatf("tbl%0d_data", r), gt_data, tbl[r].xd);
      chk($sformatf("tbl%0d_ctrl", r), 32'(gt_ctrl), 32'(tbl[r].xc));
      chk($sformatf("tbl%0d_ready", r), 32'(sif.s_ready), 32'(tbl[r].xr));
      chk($sformatf("tbl%0d_done", r), 32'(frame_done), 32'(tbl[r].xdone));
      chk($sformatf("tbl%0d_trunc", r), 32'(trunc_err), 32'(tbl[r].xtrunc));
    end

    // no source data: idle forever
    do_reset();
    repeat (20) cycle();
    chk("idle_no_sof", 32'(sofs), 0);

    // underrun of 2 cycles; s_last lands together with MAX_WORDS
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back('{32'hD000_0000 + 32'(i), i == 3});
    run_until_frame(1, 40, "underrun_reach");
    drop = 2; f0 = frames; fl0 = fills; t0 = truncs;
    repeat (12) cycle();
    chk("underrun_fills", 32'(fills - fl0), 2);
    chk("underrun_frames", 32'(frames - f0), 1);
    chk("last_at_max_no_trunc", 32'(truncs - t0), 0);

    // 6-word source, no s_last in first 4: cut at 4, rest becomes next frame
    do_reset();
    for (int i = 0; i < 6; i++) src_q.push_back('{32'hE000_0000 + 32'(i), i == 5});
    f0 = frames; t0 = truncs;
    repeat (40) cycle();
    chk("trunc_pulses", 32'(truncs - t0), 1);
    chk("trunc_frames", 32'(frames - f0), 2);

    // tx_en drop mid-frame
    do_reset();
    auto_gen = 1;
    run_until_frame(1, 60, "txen_reach");
    en_req = 0; f0 = frames;
    repeat (40) cycle();
    chk("txen_off_frames", 32'(frames - f0), 1);
    chk("txen_off_idle", 32'(m_in), 0);
    en_req = 1;
    repeat (2) cycle();
    chk("txen_on_sof", 32'(m_in), 1);

    // reset during payload
    run_until_frame(1, 60, "rst_mid_reach");
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("rst_mid_data", gt_data, IDLE);
    chk("rst_mid_ctrl", 32'(gt_ctrl), 32'(K));
    chk("rst_mid_ready", 32'(sif.s_ready), 0);
    chk("rst_mid_done", 32'(frame_done), 0);
    do_reset();
    f0 = sofs;
    repeat (30) cycle();
    chk("rst_mid_restart", 32'(sofs - f0 > 0), 1);

    // random traffic with underruns and tx_en toggling
    do_reset();
    prob = 75; rand_en = 1; f0 = frames;
    repeat (3000) cycle();
    chk("rand_progress", 32'(frames - f0 > 20), 1);
    chk("rand_saw_trunc", 32'(truncs > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
